gray_to_binary_stream_decoder: RTL and testbench
================================================

// Module: gray_to_binary_stream_decoder
// PURPOSE
// - Registered, parameterised Gray-to-binary decoder: the receive-side inverse of the
//   Gray encoder.
// - Sits between a Gray-coded source (position encoder, async-FIFO pointer) and
//   binary-domain logic.
// - Accepts codes over a valid/ready handshake and returns the binary value one
//   cycle later.
// - Checks that consecutive accepted codes are unit steps, reports the direction,
//   and keeps a saturating error count.
// PARAMETERS
// - WIDTH      4   code width in bits, >= 2
// - ERR_CNT_W  8   width of the saturating step-error counter, >= 1
// PORTS
// - Clock            in   1          rising-edge clock
// - Reset_n          in   1          synchronous reset, active low
// - Gray_Code_In     in   WIDTH      Gray code to decode
// - In_Valid         in   1          Gray_Code_In is valid
// - In_Ready         out  1          decoder can accept this cycle
// - Binary_Code_Out  out  WIDTH      decoded binary value
// - Out_Valid        out  1          output word valid
// - Out_Ready        in   1          downstream accepts output word
// - Step_Up          out  1          output word = previous + 1 (mod 2^WIDTH)
// - Step_Down        out  1          output word = previous - 1 (mod 2^WIDTH)
// - Step_Hold        out  1          output word = previous
// - Step_Error       out  1          output word is none of the above
// - Error_Count      out  ERR_CNT_W  saturating count of Step_Error words
// - Clear_Errors     in   1          synchronous clear of Error_Count
// BEHAVIOUR
// - Reset (Reset_n=0 at a rising edge):
//   - Binary_Code_Out=0; Out_Valid=0; all Step_* = 0; Error_Count=0.
//   - Internal Have_Prev=0; Prev_Binary=0.
//   - Mid-transfer reset discards the held word with no partial output.
// - Decode: B[WIDTH-1]=G[WIDTH-1]; B[i]=B[i+1]^G[i] for i=WIDTH-2..0. Pure XOR
//   prefix, no arithmetic carry.
// - Handshake:
//   - In_Ready = ~Out_Valid | Out_Ready (combinational; zero-bubble single register).
//   - Accept happens when In_Valid & In_Ready at a rising edge.
//   - On accept: Binary_Code_Out and Step_* load and Out_Valid=1 from the next cycle.
//     Latency is 1 cycle.
//   - Out_Valid & Out_Ready without an accept: Out_Valid=0 next cycle; data and flags
//     hold their last values.
//   - Out_Valid & ~Out_Ready: output word and flags hold stable; In_Ready=0.
//   - Simultaneous output consume and input accept: new word loads; Out_Valid stays 1.
// - Step classification, computed on accept from the new binary value N and
//   Prev_Binary P:
//   - First word after reset (Have_Prev=0): all Step_* = 0; not an error.
//   - Otherwise exactly one flag is set, in this priority:
//     Hold (N==P), Up (N==P+1 mod 2^WIDTH), Down (N==P-1 mod 2^WIDTH), else Error.
//   - WIDTH=2 has no ambiguity beyond this priority; wrap 2^WIDTH-1 -> 0 counts as Up.
//   - On every accept: Prev_Binary=N and Have_Prev=1.
// - Error_Count:
//   - Increments by 1 on each accept classified Error.
//   - Saturates at 2^ERR_CNT_W-1.
//   - Clear_Errors=1 forces 0 next cycle and takes priority over an increment in the
//     same cycle.
//   - Clear_Errors does not affect Prev_Binary or the data path.
// - Step_* change only on accept and otherwise hold; they are meaningful only while
//   Out_Valid=1.
// TESTING
// - Decode check (WIDTH=4), Out_Ready=1, back-to-back inputs:
//   - Gray 0000, 0001, 0011, 1000, 1001 -> binary 0000, 0001, 0010, 1111, 1110.
//   - Each result appears 1 cycle after its input.
// - Full Gray up-sweep 0..15 then wrap to 0:
//   - First word: all Step_* = 0.
//   - Every later word: Step_Up=1.
//   - Error_Count=0 at end.
// - Jump and direction check: Gray 0001 (bin 1) then 1001 (bin 14), then 1000
//   (bin 15), then 1000 again:
//   - 1001 gives Step_Error=1 and Error_Count=1.
//   - 1000 gives Step_Up=1.
//   - Repeated 1000 gives Step_Hold=1.
//   - Next 1000 -> 1001 gives Step_Down=1.
// - Backpressure: hold Out_Ready=0 for 3 cycles while In_Valid=1:
//   - In_Ready=0 and the output word holds stable throughout.
//   - On Out_Ready=1, the pending input is accepted in the same cycle; no loss or
//     duplication.
// - ERR_CNT_W=2: drive 5 error steps -> Error_Count saturates at 3.
//   - Clear_Errors pulsed with a simultaneous error step -> Error_Count=0.
// - Reset mid-stream with Out_Valid=1 and Out_Ready=0:
//   - Next cycle Out_Valid=0 and Error_Count=0.
//   - First word after reset has all Step_* = 0.

Source files
------------

// File: rtl/gray_to_binary_stream_decoder.sv
// rtl/gray_to_binary_stream_decoder.sv - registered Gray-to-binary decoder with step classification
module gray_to_binary_stream_decoder #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic [WIDTH-1:0]     Gray_Code_In,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    output logic [WIDTH-1:0]     Binary_Code_Out,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic                 Step_Up,
    output logic                 Step_Down,
    output logic                 Step_Hold,
    output logic                 Step_Error,
    output logic [ERR_CNT_W-1:0] Error_Count,
    input  logic                 Clear_Errors
);

    localparam logic [WIDTH-1:0]     ONE     = WIDTH'(1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0]     bin_q, bin_d;
    logic                 out_valid_q, out_valid_d;
    logic                 have_prev_q, have_prev_d;
    logic                 step_up_q, step_up_d;
    logic                 step_down_q, step_down_d;
    logic                 step_hold_q, step_hold_d;
    logic                 step_error_q, step_error_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 accept;
    logic [WIDTH-1:0]     dec_bin;
    logic                 is_hold, is_up, is_down;

    assign In_Ready = ~out_valid_q | Out_Ready;
    assign accept   = In_Valid & In_Ready;
    assign dec_bin  = gray_to_bin(Gray_Code_In);

    // The output register always carries the last accepted value, so it doubles
    // as the previous-value reference for step classification.
    assign is_hold  = (dec_bin == bin_q);
    assign is_up    = (dec_bin == (bin_q + ONE));
    assign is_down  = (dec_bin == (bin_q - ONE));

    always_comb begin
        bin_d        = bin_q;
        out_valid_d  = out_valid_q;
        have_prev_d  = have_prev_q;
        step_up_d    = step_up_q;
        step_down_d  = step_down_q;
        step_hold_d  = step_hold_q;
        step_error_d = step_error_q;
        err_cnt_d    = err_cnt_q;

        if (accept) begin
            bin_d        = dec_bin;
            out_valid_d  = 1'b1;
            have_prev_d  = 1'b1;
            step_hold_d  = have_prev_q & is_hold;
            step_up_d    = have_prev_q & ~is_hold & is_up;
            step_down_d  = have_prev_q & ~is_hold & ~is_up & is_down;
            step_error_d = have_prev_q & ~is_hold & ~is_up & ~is_down;
        end else if (out_valid_q && Out_Ready) begin
            out_valid_d = 1'b0;
        end

        if (Clear_Errors) begin
            err_cnt_d = '0;
        end else if (accept && step_error_d && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            bin_q        <= '0;
            out_valid_q  <= 1'b0;
            have_prev_q  <= 1'b0;
            step_up_q    <= 1'b0;
            step_down_q  <= 1'b0;
            step_hold_q  <= 1'b0;
            step_error_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            bin_q        <= bin_d;
            out_valid_q  <= out_valid_d;
            have_prev_q  <= have_prev_d;
            step_up_q    <= step_up_d;
            step_down_q  <= step_down_d;
            step_hold_q  <= step_hold_d;
            step_error_q <= step_error_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign Binary_Code_Out = bin_q;
    assign Out_Valid       = out_valid_q;
    assign Step_Up         = step_up_q;
    assign Step_Down       = step_down_q;
    assign Step_Hold       = step_hold_q;
    assign Step_Error      = step_error_q;
    assign Error_Count     = err_cnt_q;

endmodule

// File: tb/tb_gray_to_binary_stream_decoder.sv
// tb/tb_gray_to_binary_stream_decoder.sv - scoreboard bench for gray_to_binary_stream_decoder
module tb_gray_to_binary_stream_decoder;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_UP   = 4'b1000;
    localparam logic [3:0] F_DN   = 4'b0100;
    localparam logic [3:0] F_HD   = 4'b0010;
    localparam logic [3:0] F_ER   = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] gray_in;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] bin_out;
    logic       out_valid;
    logic       out_ready;
    logic       step_up, step_down, step_hold, step_error;
    logic [1:0] err_cnt;
    logic       clr_err;

    typedef struct {
        logic [3:0] bin;
        logic [3:0] flags;
        logic [1:0] cnt;
        int         cyc;
        bit         strict;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gray_to_binary_stream_decoder #(.WIDTH(4), .ERR_CNT_W(2)) dut (
        .Clock(clk), .Reset_n(rst_n), .Gray_Code_In(gray_in), .In_Valid(in_valid),
        .In_Ready(in_ready), .Binary_Code_Out(bin_out), .Out_Valid(out_valid),
        .Out_Ready(out_ready), .Step_Up(step_up), .Step_Down(step_down),
        .Step_Hold(step_hold), .Step_Error(step_error), .Error_Count(err_cnt),
        .Clear_Errors(clr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed output handshake pops one expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got bin=%0h with empty scoreboard", bin_out);
            end else begin
                exp_t e;
                logic [3:0] fl;
                e  = exp_q.pop_front();
                fl = {step_up, step_down, step_hold, step_error};
                if (bin_out !== e.bin || fl !== e.flags || err_cnt !== e.cnt ||
                    (e.strict && cyc != e.cyc + 1)) begin
                    n_fail++;
                    $display("FAIL word: got bin=%0h flags=%b cnt=%0d lat=%0d expected bin=%0h flags=%b cnt=%0d lat=1",
                             bin_out, fl, err_cnt, cyc - e.cyc, e.bin, e.flags, e.cnt);
                end
            end
        end
    end

    task automatic send(input logic [3:0] g, input logic [3:0] eb, input logic [3:0] ef,
                        input logic [1:0] ec, input bit strict);
        bit ok;
        exp_t e;
        ok       = 1'b0;
        gray_in  = g;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: gray=%b not accepted within 50 cycles, expected accept", g);
        end else begin
            e.bin = eb; e.flags = ef; e.cnt = ec; e.cyc = cyc; e.strict = strict;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        logic [3:0] v;
        rst_n = 1'b0; gray_in = '0; in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_bin", 32'(bin_out), 32'd0);
        chk("reset_flags", 32'({step_up, step_down, step_hold, step_error}), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Decode, back-to-back with strict one-cycle latency
        send(4'b0000, 4'b0000, F_NONE, 2'd0, 1'b1);
        send(4'b0001, 4'b0001, F_UP,   2'd0, 1'b1);
        send(4'b0011, 4'b0010, F_UP,   2'd0, 1'b1);
        send(4'b1000, 4'b1111, F_ER,   2'd1, 1'b1);
        send(4'b1001, 4'b1110, F_DN,   2'd1, 1'b1);
        idle(2);

        // Full up-sweep with wrap
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            v = 4'(i);
            send(v ^ (v >> 1), v, (i == 0) ? F_NONE : F_UP, 2'd0, 1'b1);
        end
        idle(2);
        @(negedge clk);
        chk("sweep_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk); #1;

        // Jump and direction
        do_reset();
        send(4'b0001, 4'd1,  F_NONE, 2'd0, 1'b0);
        send(4'b1001, 4'd14, F_ER,   2'd1, 1'b0);
        send(4'b1000, 4'd15, F_UP,   2'd1, 1'b0);
        send(4'b1000, 4'd15, F_HD,   2'd1, 1'b0);
        send(4'b1001, 4'd14, F_DN,   2'd1, 1'b0);
        idle(1);

        // Backpressure: word 13 held while word 12 waits
        out_ready = 1'b0;
        send(4'b1011, 4'd13, F_DN, 2'd1, 1'b0);
        gray_in  = 4'b1010;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_bin_hold", 32'(bin_out), 32'd13);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(4'b1010, 4'd12, F_DN, 2'd1, 1'b0);
        idle(2);

        // Error counter saturation at 3 and clear priority
        do_reset();
        send(4'b0000, 4'd0, F_NONE, 2'd0, 1'b0);
        send(4'b1100, 4'd8, F_ER,   2'd1, 1'b0);
        send(4'b0000, 4'd0, F_ER,   2'd2, 1'b0);
        send(4'b1100, 4'd8, F_ER,   2'd3, 1'b0);
        send(4'b0000, 4'd0, F_ER,   2'd3, 1'b0);
        send(4'b1100, 4'd8, F_ER,   2'd3, 1'b0);
        clr_err = 1'b1;
        send(4'b0000, 4'd0, F_ER,   2'd0, 1'b0);
        clr_err = 1'b0;
        idle(1);

        // Reset while a word is held under backpressure
        send(4'b1100, 4'd8, F_ER, 2'd1, 1'b0);
        idle(1);
        out_ready = 1'b0;
        send(4'b1101, 4'd9, F_UP, 2'd1, 1'b0);
        @(negedge clk);
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        chk("pre_reset_err_cnt", 32'(err_cnt), 32'd1);
        do_reset();
        @(negedge clk);
        chk("post_reset_out_valid", 32'(out_valid), 32'd0);
        chk("post_reset_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'b0011, 4'd2, F_NONE, 2'd0, 1'b0);

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) idle(1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
